// File: rtl/sample_capture.sv
// sample_capture: decimating, level-triggered acquisition front end for draw_display.
// Accepted samples go to a shadow buffer. A finished record is copied into the
// display array in a single cycle on a rising vblnk edge, so the renderer never
// sees a half-updated record.
module sample_capture #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 256,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_auto,
  input  logic [3:0]        decim,
  input  logic              vblnk,
  output logic [DATA_W-1:0] data_display [0:DEPTH-1],
  output logic              capture_done,
  output logic              triggered
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TO_W  = $clog2(AUTO_TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARM        = 2'd0,
    ST_WAIT_TRIG  = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_WAIT_FRAME = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        dcnt_q, dcnt_d;        // decimation phase counter
  logic [3:0]        dlim_q, dlim_d;        // decimation limit, refreshed only at a wrap
  logic [DATA_W-1:0] prev_q, prev_d;        // previous accepted sample while waiting
  logic [TO_W-1:0]   tcnt_q, tcnt_d;        // auto-mode timeout counter (saturating)
  logic [IDX_W-1:0]  idx_q, idx_d;          // next shadow write index
  logic              trig_flag_q, trig_flag_d;
  logic              vblnk_dly_q, vblnk_dly_d;
  logic              capture_done_q, capture_done_d;
  logic              triggered_q, triggered_d;

  logic              accept_s;
  logic [3:0]        dlim_s;
  logic              vblnk_rise_s;
  logic              commit_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  logic [DATA_W-1:0] shadow_q  [0:DEPTH-1];
  logic [DATA_W-1:0] display_q [0:DEPTH-1];

  // Decimation: a sample is accepted when the phase counter is zero. The limit
  // is re-read from decim at the start of each period so a change lands cleanly
  // at the next wrap; entering ARM restarts the phase.
  always_comb begin
    dcnt_d   = dcnt_q;
    dlim_d   = dlim_q;
    accept_s = adc_valid && (dcnt_q == 4'd0);
    if (dcnt_q == 4'd0) begin
      dlim_s = decim;
    end else begin
      dlim_s = dlim_q;
    end
    if (adc_valid) begin
      if (dcnt_q == 4'd0) begin
        dlim_d = decim;
      end else begin
        dlim_d = dlim_q;
      end
      if (dcnt_q == dlim_s) begin
        dcnt_d = 4'd0;
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end else begin
      dcnt_d = dcnt_q;
    end
    if (commit_s) begin
      dcnt_d = 4'd0;
    end else begin
      dcnt_d = dcnt_d;
    end
  end

  // Acquisition FSM: next state, shadow write port, and commit control.
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    tcnt_d         = tcnt_q;
    idx_d          = idx_q;
    trig_flag_d    = trig_flag_q;
    triggered_d    = triggered_q;
    capture_done_d = 1'b0;
    vblnk_dly_d    = vblnk;
    vblnk_rise_s   = vblnk && !vblnk_dly_q;
    commit_s       = 1'b0;
    wr_en_s        = 1'b0;
    wr_addr_s      = idx_q;
    wr_data_s      = adc_data;

    case (state_q)
      ST_ARM: begin
        if (accept_s) begin
          prev_d  = adc_data;
          tcnt_d  = {TO_W{1'b0}};
          state_d = ST_WAIT_TRIG;
        end else begin
          state_d = ST_ARM;
        end
      end

      ST_WAIT_TRIG: begin
        if (accept_s) begin
          if ((prev_q < trig_level) && (adc_data >= trig_level)) begin
            wr_en_s     = 1'b1;
            wr_addr_s   = {IDX_W{1'b0}};
            trig_flag_d = 1'b1;
            idx_d       = IDX_W'(1);
            state_d     = ST_CAPTURE;
          end else if (trig_auto && (tcnt_q == TO_LAST)) begin
            wr_en_s     = 1'b1;
            wr_addr_s   = {IDX_W{1'b0}};
            trig_flag_d = 1'b0;
            idx_d       = IDX_W'(1);
            state_d     = ST_CAPTURE;
          end else begin
            prev_d = adc_data;
            // Hold at the last value so late switching to auto mode still forces.
            if (tcnt_q != TO_LAST) begin
              tcnt_d = tcnt_q + TO_W'(1);
            end else begin
              tcnt_d = tcnt_q;
            end
          end
        end else begin
          state_d = ST_WAIT_TRIG;
        end
      end

      ST_CAPTURE: begin
        if (accept_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = idx_q;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = ST_WAIT_FRAME;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_WAIT_FRAME: begin
        if (vblnk_rise_s) begin
          commit_s       = 1'b1;
          triggered_d    = trig_flag_q;
          capture_done_d = 1'b1;
          state_d        = ST_ARM;
        end else begin
          state_d = ST_WAIT_FRAME;
        end
      end

      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ARM;
      dcnt_q         <= 4'd0;
      dlim_q         <= 4'd0;
      prev_q         <= {DATA_W{1'b0}};
      tcnt_q         <= {TO_W{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      trig_flag_q    <= 1'b0;
      vblnk_dly_q    <= 1'b0;
      capture_done_q <= 1'b0;
      triggered_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      dlim_q         <= dlim_d;
      prev_q         <= prev_d;
      tcnt_q         <= tcnt_d;
      idx_q          <= idx_d;
      trig_flag_q    <= trig_flag_d;
      vblnk_dly_q    <= vblnk_dly_d;
      capture_done_q <= capture_done_d;
      triggered_q    <= triggered_d;
    end
  end

  // Shadow buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      shadow_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Display array: cleared by reset, otherwise replaced wholesale on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        display_q[i] <= {DATA_W{1'b0}};
      end
    end else if (commit_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        display_q[i] <= shadow_q[i];
      end
    end
  end

  assign data_display = display_q;
  assign capture_done = capture_done_q;
  assign triggered    = triggered_q;

endmodule

// File: doc/sample_capture.md
# sample_capture

Acquisition stage directly upstream of `draw_display`: accepts a stream of 12-bit ADC samples, applies decimation and rising-edge level triggering, and records 256 consecutive samples into a shadow buffer. A completed record is copied into the `data_display` array only at the start of a vertical blanking interval, so the renderer never draws a mixed frame. The array is then held stable until the next committed record.

## Interface
Parameters:
- `DATA_W`, 12: sample width; must match the `draw_display` data width.
- `DEPTH`, 256: record length; must be a power of two; index width is log2(DEPTH).
- `AUTO_TIMEOUT`, 1024: number of accepted samples without a trigger before auto mode forces a capture.

Ports:
- `clk` input 1: pixel/system clock.
- `rst` input 1: reset; synchronous, active-high.
- `adc_data` input DATA_W: ADC sample.
- `adc_valid` input 1: `adc_data` is valid this cycle.
- `trig_level` input DATA_W: trigger threshold, unsigned.
- `trig_auto` input 1: 1 = auto mode, 0 = normal mode (wait indefinitely for a trigger).
- `decim` input 4: accept one of every `decim`+1 valid samples.
- `vblnk` input 1: vertical blanking from the VGA timing chain.
- `data_display` output DATA_W x [0:DEPTH-1]: committed record, index 0 = trigger sample.
- `capture_done` output 1: one-cycle pulse when a record is committed.
- `triggered` output 1: 1 = last committed record was level-triggered; 0 = auto-forced.

## Operation
- Accepted sample: `adc_valid` is 1 and the decimation counter is 0.
  - The counter increments on each `adc_valid` and wraps from `decim` to 0.
  - The counter clears on entry to ARM.
  - A change to `decim` takes effect at the next wrap.
- States:
  - **ARM**: on the first accepted sample, store it in `prev`, clear the timeout counter, go to WAIT_TRIG.
  - **WAIT_TRIG**: on each accepted sample `cur`:
    - Crossing (`prev` < `trig_level` and `cur` >= `trig_level`): write `cur` to shadow[0], set `trig_flag`=1, set index=1, go to CAPTURE.
    - Otherwise, if `trig_auto`=1 and the timeout counter equals AUTO_TIMEOUT-1: write `cur` to shadow[0], set `trig_flag`=0, set index=1, go to CAPTURE.
    - Otherwise: set `prev` = `cur` and increment the timeout counter. The timeout counter saturates and never wraps.
  - **CAPTURE**: on each accepted sample, write it to shadow[index] and increment index. After the write to index DEPTH-1, go to WAIT_FRAME. Index arithmetic is log2(DEPTH) bits, unsigned.
  - **WAIT_FRAME**: ignore all samples. On a rising edge of `vblnk` (`vblnk`=1 and registered `vblnk_d`=0):
    - copy the whole shadow buffer into `data_display` in one cycle;
    - set `triggered` = `trig_flag`;
    - pulse `capture_done`;
    - go to ARM.
- Edge cases:
  - The trigger comparison is unsigned and `>=`. A sample equal to `trig_level` counts as crossed; a `prev` equal to `trig_level` does not qualify as "below".
  - If `vblnk` is already high when WAIT_FRAME is entered, the block waits for the next rising edge.
  - `trig_level` and `trig_auto` are sampled live every cycle; changing them mid-capture does not abort the capture.

## Timing
- Reset values:
  - `data_display` all zero; `capture_done`=0; `triggered`=0.
  - State ARM; decimation, timeout and index counters 0; `vblnk_d`=0.
  - Shadow contents are don't-care.
- Reset mid-operation: the partial record is discarded and `data_display` clears on the reset cycle.
- Per-sample latency: a shadow write occurs in the cycle after an accepted sample is presented (registered).
- Commit: `vblnk` rises at cycle N, so `vblnk_d` is still 0 at N.
  - `data_display`, `triggered` and `capture_done`=1 are all visible at cycle N+1.
  - `capture_done` returns to 0 at N+2.
  - The state is ARM at N+1. A sample presented at N+1 is accepted as the ARM sample (decimation counter already 0).
- Minimum spacing between commits: DEPTH+1 accepted samples plus the wait for a `vblnk` rising edge. At most one commit per frame.

## Test plan
- **Ramp trigger**: `decim`=0, `trig_level`=0x800, `adc_valid` held 1, ramp 0x7F0, 0x7F8, 0x800, 0x808, …. After the next `vblnk` rise, `data_display[0]`=0x800, `data_display[1]`=0x808, `data_display[255]`=0x800+255*8 mod 4096, `triggered`=1, `capture_done` pulses exactly one cycle.
- **Auto timeout**: `trig_auto`=1, constant input 0x100, `trig_level`=0x800. Capture is forced on the 1024th WAIT_TRIG sample; all entries are 0x100; `triggered`=0.
- **Normal mode, no trigger**: `trig_auto`=0, constant input. No `capture_done` over 5000 samples; `data_display` stays zero.
- **Decimation**: `decim`=3, counter input 0,1,2,… with trigger at the sample equal to 0x800 (`trig_level`=0x800, counter start chosen so that 0x800 is an accepted sample). Consecutive entries differ by 4.
- **Frame gating**: capture completes while `vblnk`=1. No commit until `vblnk` falls and rises again; `data_display` unchanged in between.
- **Reset mid-capture**: assert `rst` for 1 cycle at index 100. `data_display` = 0 the next cycle, state ARM, and a subsequent full capture commits correctly.
